// File: rtl/btf_unified_pipe.sv
// Streaming radix-2 NTT/INTT butterfly with per-beat CT/GS mode selection, optional
// halving, and a credit-limited output FIFO so the arithmetic pipeline never stalls.
module btf_unified_pipe #(
  parameter int              LOGQ       = 64,
  parameter int              IS_Q_FIXED = 0,
  parameter logic [LOGQ-1:0] Q          = {LOGQ{1'b0}},
  parameter int              DELAY_ADD  = 1,
  parameter int              DELAY_SUB  = 1,
  parameter int              DELAY_MUL  = 4,
  parameter int              DELAY_RED  = 4,
  parameter int              FIFO_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            mode,
  input  logic            div2_en,
  input  logic [LOGQ-1:0] in_a,
  input  logic [LOGQ-1:0] in_b,
  input  logic [LOGQ-1:0] in_w,
  input  logic [LOGQ-1:0] q,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LOGQ-1:0] out_a,
  output logic [LOGQ-1:0] out_b
);

  localparam int LAT = DELAY_ADD + DELAY_MUL + DELAY_RED + 1;
  localparam int MR  = DELAY_MUL + DELAY_RED;
  localparam int PQ  = 2 * LOGQ;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic [LOGQ-1:0] mod_add(input logic [LOGQ-1:0] x, input logic [LOGQ-1:0] y,
                                              input logic [LOGQ-1:0] m);
    logic [LOGQ:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    else                s = s;
    return s[LOGQ-1:0];
  endfunction

  function automatic logic [LOGQ-1:0] mod_sub(input logic [LOGQ-1:0] x, input logic [LOGQ-1:0] y,
                                              input logic [LOGQ-1:0] m);
    if (x >= y) return x - y;
    else        return x + (m - y);
  endfunction

  function automatic logic [LOGQ-1:0] mod_red(input logic [PQ-1:0] p, input logic [LOGQ-1:0] m);
    return LOGQ'(p % {{LOGQ{1'b0}}, m});
  endfunction

  // Odd values borrow q so the shift stays exact; the sum needs one extra bit.
  function automatic logic [LOGQ-1:0] mod_div2(input logic [LOGQ-1:0] x, input logic [LOGQ-1:0] m);
    logic [LOGQ:0] s;
    if (x[0]) s = {1'b0, x} + {1'b0, m};
    else      s = {1'b0, x};
    return LOGQ'(s >> 1);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) return {PW{1'b0}};
    else                          return p + {{(PW-1){1'b0}}, 1'b1};
  endfunction

  logic [LOGQ-1:0] q_s;
  assign q_s = (IS_Q_FIXED != 0) ? Q : q;

  logic [PQ-1:0]   ct_mul_r   [DELAY_MUL];
  logic [LOGQ-1:0] ct_red_r   [DELAY_RED];
  logic [LOGQ-1:0] ct_a_r     [MR];
  logic [LOGQ-1:0] ct_sum_r   [DELAY_ADD];
  logic [LOGQ-1:0] ct_dif_r   [DELAY_SUB];
  logic [LOGQ-1:0] gs_sum_r   [DELAY_ADD];
  logic [LOGQ-1:0] gs_dif_r   [DELAY_SUB];
  logic [LOGQ-1:0] gs_w_r     [DELAY_SUB];
  logic [PQ-1:0]   gs_mul_r   [DELAY_MUL];
  logic [LOGQ-1:0] gs_red_r   [DELAY_RED];
  logic [LOGQ-1:0] gs_sum_d_r [MR];
  logic [LOGQ-1:0] pre_a_s, pre_b_s, res_a_r, res_b_r;

  logic [LAT-1:0]  tag_v_r;
  logic [LAT-2:0]  tag_m_r, tag_d_r;
  state_t          state_r;
  logic            cur_mode_r, in_ready_r, accept_s, wr_s, pop_s, credit_ok_s;
  logic [CW-1:0]   inflight_r, inflight_nxt_s, count_r, count_nxt_s;
  logic [CW:0]     credit_sum_s;
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r, rd_nxt_s;
  logic [LOGQ-1:0] mem_a_r [FIFO_DEPTH];
  logic [LOGQ-1:0] mem_b_r [FIFO_DEPTH];
  logic            out_valid_r;
  logic [LOGQ-1:0] out_a_r, out_b_r;

  // Both datapaths run every cycle; the mode tag picks which one reaches the FIFO.
  always_ff @(posedge clk) begin
    ct_mul_r[0] <= PQ'(in_b) * PQ'(in_w);
    for (int i = 1; i < DELAY_MUL; i++) ct_mul_r[i] <= ct_mul_r[i-1];
    ct_red_r[0] <= mod_red(ct_mul_r[DELAY_MUL-1], q_s);
    for (int i = 1; i < DELAY_RED; i++) ct_red_r[i] <= ct_red_r[i-1];
    ct_a_r[0] <= in_a;
    for (int i = 1; i < MR; i++) ct_a_r[i] <= ct_a_r[i-1];
    ct_sum_r[0] <= mod_add(ct_a_r[MR-1], ct_red_r[DELAY_RED-1], q_s);
    for (int i = 1; i < DELAY_ADD; i++) ct_sum_r[i] <= ct_sum_r[i-1];
    ct_dif_r[0] <= mod_sub(ct_a_r[MR-1], ct_red_r[DELAY_RED-1], q_s);
    for (int i = 1; i < DELAY_SUB; i++) ct_dif_r[i] <= ct_dif_r[i-1];

    gs_sum_r[0] <= mod_add(in_a, in_b, q_s);
    for (int i = 1; i < DELAY_ADD; i++) gs_sum_r[i] <= gs_sum_r[i-1];
    gs_dif_r[0] <= mod_sub(in_a, in_b, q_s);
    gs_w_r[0]   <= in_w;
    for (int i = 1; i < DELAY_SUB; i++) begin
      gs_dif_r[i] <= gs_dif_r[i-1];
      gs_w_r[i]   <= gs_w_r[i-1];
    end
    gs_mul_r[0] <= PQ'(gs_dif_r[DELAY_SUB-1]) * PQ'(gs_w_r[DELAY_SUB-1]);
    for (int i = 1; i < DELAY_MUL; i++) gs_mul_r[i] <= gs_mul_r[i-1];
    gs_red_r[0] <= mod_red(gs_mul_r[DELAY_MUL-1], q_s);
    for (int i = 1; i < DELAY_RED; i++) gs_red_r[i] <= gs_red_r[i-1];
    gs_sum_d_r[0] <= gs_sum_r[DELAY_ADD-1];
    for (int i = 1; i < MR; i++) gs_sum_d_r[i] <= gs_sum_d_r[i-1];

    res_a_r <= tag_d_r[LAT-2] ? mod_div2(pre_a_s, q_s) : pre_a_s;
    res_b_r <= tag_d_r[LAT-2] ? mod_div2(pre_b_s, q_s) : pre_b_s;
  end

  // Select the datapath matching the beat that is about to enter the halving stage.
  always_comb begin
    pre_a_s = ct_sum_r[DELAY_ADD-1];
    pre_b_s = ct_dif_r[DELAY_SUB-1];
    if (tag_m_r[LAT-2]) begin
      pre_a_s = gs_sum_d_r[MR-1];
      pre_b_s = gs_red_r[DELAY_RED-1];
    end else begin
      pre_a_s = ct_sum_r[DELAY_ADD-1];
      pre_b_s = ct_dif_r[DELAY_SUB-1];
    end
  end

  assign in_ready       = in_ready_r && ((state_r != ST_RUN) || (mode == cur_mode_r));
  assign accept_s       = in_valid && in_ready;
  assign wr_s           = tag_v_r[LAT-1];
  assign pop_s          = out_valid_r && out_ready;
  assign inflight_nxt_s = inflight_r + CW'(accept_s) - CW'(wr_s);
  assign count_nxt_s    = count_r + CW'(wr_s) - CW'(pop_s);
  assign rd_nxt_s       = pop_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
  // Credit counts every beat that will land in the FIFO, so a write is never refused.
  assign credit_sum_s   = {1'b0, inflight_nxt_s} + {1'b0, count_nxt_s};
  assign credit_ok_s    = credit_sum_s < (CW+1)'(FIFO_DEPTH);

  // Tag pipe, in-flight counter and mode FSM; in_ready is registered one cycle ahead.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_v_r    <= {LAT{1'b0}};
      tag_m_r    <= {(LAT-1){1'b0}};
      tag_d_r    <= {(LAT-1){1'b0}};
      inflight_r <= {CW{1'b0}};
      state_r    <= ST_IDLE;
      cur_mode_r <= 1'b0;
      in_ready_r <= 1'b0;
    end else begin
      tag_v_r    <= {tag_v_r[LAT-2:0], accept_s};
      tag_m_r    <= {tag_m_r[LAT-3:0], mode};
      tag_d_r    <= {tag_d_r[LAT-3:0], div2_en};
      inflight_r <= inflight_nxt_s;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r    <= ST_RUN;
            cur_mode_r <= mode;
          end else begin
            state_r    <= ST_IDLE;
          end
          in_ready_r <= credit_ok_s;
        end
        ST_RUN: begin
          if (in_valid && (mode != cur_mode_r) && (inflight_nxt_s != {CW{1'b0}})) begin
            state_r    <= ST_DRAIN;
            in_ready_r <= 1'b0;
          end else begin
            if (in_valid && (mode != cur_mode_r)) cur_mode_r <= mode;
            if ((inflight_r == {CW{1'b0}}) && (count_r == {CW{1'b0}}) && !accept_s) state_r <= ST_IDLE;
            in_ready_r <= credit_ok_s;
          end
        end
        ST_DRAIN: begin
          if (inflight_nxt_s == {CW{1'b0}}) begin
            state_r    <= ST_RUN;
            cur_mode_r <= mode;
            in_ready_r <= credit_ok_s;
          end else begin
            in_ready_r <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          in_ready_r <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage; occupancy is tracked in the control block below.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_a_r[wr_ptr_r] <= res_a_r;
      mem_b_r[wr_ptr_r] <= res_b_r;
    end
  end

  // FIFO pointers and a registered head; a write into an empty FIFO bypasses storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      out_valid_r <= 1'b0;
      out_a_r     <= {LOGQ{1'b0}};
      out_b_r     <= {LOGQ{1'b0}};
    end else begin
      if (wr_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      rd_ptr_r    <= rd_nxt_s;
      count_r     <= count_nxt_s;
      out_valid_r <= (count_nxt_s != {CW{1'b0}});
      if (count_nxt_s != {CW{1'b0}}) begin
        if (wr_s && (count_r == CW'(pop_s))) begin
          out_a_r <= res_a_r;
          out_b_r <= res_b_r;
        end else begin
          out_a_r <= mem_a_r[rd_nxt_s];
          out_b_r <= mem_b_r[rd_nxt_s];
        end
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_a     = out_a_r;
  assign out_b     = out_b_r;

endmodule

// File: tb/tb_btf_unified_pipe.sv
// Directed-vector and scoreboard bench for btf_unified_pipe at LOGQ=8, q=17.
module tb_btf_unified_pipe;
  localparam int QM    = 17;
  localparam int LAT   = 10;
  localparam int DEPTH = 16;

  logic       clk, rst, in_valid, in_ready, mode, div2_en, out_valid, out_ready;
  logic [7:0] in_a, in_b, in_w, q, out_a, out_b;
  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;

  typedef struct packed { logic [7:0] a; logic [7:0] b; } res_t;
  typedef struct { bit m; bit d; int a; int b; int w; int ea; int eb; } vec_t;
  res_t sb_q[$];
  vec_t tbl[10];

  btf_unified_pipe #(.LOGQ(8), .IS_Q_FIXED(0), .Q(8'd0), .DELAY_ADD(1), .DELAY_SUB(1),
                     .DELAY_MUL(4), .DELAY_RED(4), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .div2_en(div2_en), .in_a(in_a), .in_b(in_b), .in_w(in_w), .q(q),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int half(input int x);
    return (x % 2 == 0) ? x / 2 : (x + QM) / 2;
  endfunction

  function automatic res_t ref_model(input bit m, input bit d, input int a, input int b, input int w);
    int oa, ob, t;
    res_t r;
    if (!m) begin
      t  = (b * w) % QM;
      oa = (a + t) % QM;
      ob = (a - t + QM) % QM;
    end else begin
      oa = (a + b) % QM;
      ob = (((a - b + QM) % QM) * w) % QM;
    end
    if (d) begin
      oa = half(oa);
      ob = half(ob);
    end
    r.a = 8'(oa);
    r.b = 8'(ob);
    return r;
  endfunction

  // Scoreboard: record accepted beats, compare every popped result in order.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (in_valid && in_ready)
          sb_q.push_back(ref_model(mode, div2_en, int'(in_a), int'(in_b), int'(in_w)));
        if (out_valid && out_ready) begin
          check("sb_nonempty_on_pop", int'(sb_q.size() != 0), 1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("sb_out_a", int'(out_a), int'(e.a));
            check("sb_out_b", int'(out_b), int'(e.b));
          end
        end
      end
    end
  end

  task automatic send_beat(input bit m, input bit d, input int a, input int b, input int w,
                           output int acc_cyc);
    bit got;
    got = 1'b0;
    acc_cyc = -1;
    mode = m; div2_en = d; in_a = 8'(a); in_b = 8'(b); in_w = 8'(w);
    in_valid = 1'b1;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        acc_cyc = cyc_cnt;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("beat_accepted", int'(got), 1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((sb_q.size() != 0 || out_valid) && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    check("idle_reached", int'(k < 300), 1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    int acc, acc_prev, cnt, sent;
    bit seen, took, rm;
    rst = 1'b0; in_valid = 1'b0; mode = 1'b0; div2_en = 1'b0;
    in_a = 8'd0; in_b = 8'd0; in_w = 8'd0; q = 8'd17; out_ready = 1'b1;
    tbl[0] = '{1'b0, 1'b0,  3,  5,  4,  6,  0};
    tbl[1] = '{1'b1, 1'b0,  3,  5,  4,  8,  9};
    tbl[2] = '{1'b1, 1'b1,  3,  5,  4,  4, 13};
    tbl[3] = '{1'b0, 1'b1,  3,  5,  4,  3,  0};
    tbl[4] = '{1'b0, 1'b0, 16, 16, 16,  0, 15};
    tbl[5] = '{1'b1, 1'b1,  0, 16, 16,  8,  8};
    tbl[6] = '{1'b0, 1'b1,  0,  0,  7,  0,  0};
    tbl[7] = '{1'b1, 1'b0, 16,  1,  2,  0, 13};
    tbl[8] = '{1'b0, 1'b1,  9, 11, 13,  8,  1};
    tbl[9] = '{1'b1, 1'b1,  5, 12,  3,  0, 15};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_a", int'(out_a), 0);
    check("rst_out_b", int'(out_b), 0);
    #2 rst = 1'b1;
    #1 check("in_ready_before_edge", int'(in_ready), 0);
    @(posedge clk); #1;
    check("in_ready_after_edge", int'(in_ready), 1);

    for (int i = 0; i < 10; i++) begin
      wait_idle();
      send_beat(tbl[i].m, tbl[i].d, tbl[i].a, tbl[i].b, tbl[i].w, acc);
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
        @(negedge clk);
        if (out_valid) begin
          seen = 1'b1;
          check("tbl_latency", cyc_cnt - acc, LAT + 1);
          check("tbl_out_a", int'(out_a), tbl[i].ea);
          check("tbl_out_b", int'(out_b), tbl[i].eb);
        end
      end
      check("tbl_out_seen", int'(seen), 1);
    end

    // Back-pressure: fill exactly to the credit limit, then drain in order.
    wait_idle();
    out_ready = 1'b0; mode = 1'b0; div2_en = 1'b0;
    in_a = 8'd0; in_b = 8'd1; in_w = 8'd1; in_valid = 1'b1;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (in_ready) cnt++;
      @(posedge clk); #1;
      in_a = 8'(cnt % QM);
    end
    check("bp_accepted", cnt, DEPTH);
    @(negedge clk);
    check("bp_in_ready_low", int'(in_ready), 0);
    check("bp_out_valid", int'(out_valid), 1);
    check("bp_head_a", int'(out_a), 1);
    check("bp_head_b", int'(out_b), 16);
    repeat (3) @(negedge clk);
    check("bp_hold_a", int'(out_a), 1);
    check("bp_hold_b", int'(out_b), 16);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid && out_ready) cnt++;
    end
    check("bp_popped", cnt, DEPTH);

    // Alternating modes: each switch waits for the pipe to empty.
    wait_idle();
    acc_prev = 0;
    for (int i = 0; i < 6; i++) begin
      send_beat(1'(i % 2), 1'b0, 2 + i, 7, 3 + i, acc);
      if (i > 0) check("switch_gap", acc - acc_prev, LAT + 1);
      acc_prev = acc;
    end

    // Reset mid-stream discards everything buffered or in flight.
    wait_idle();
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) send_beat(1'b0, 1'b1, i, 3, 5, acc);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check("pre_rst_out_valid", int'(out_valid), 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_in_ready", int'(in_ready), 0);
    check("mid_rst_out_a", int'(out_a), 0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1; out_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("post_rst_no_stale", cnt, 0);

    // Random beats with random valid/ready pacing against the model.
    wait_idle();
    sent = 0; rm = 1'b0;
    for (int k = 0; k < 30000 && sent < 1500; k++) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 7) == 0) rm = ~rm;
        mode = rm;
        div2_en = 1'($urandom_range(0, 1));
        in_a = 8'($urandom_range(0, 16));
        in_b = 8'($urandom_range(0, 16));
        in_w = 8'($urandom_range(0, 16));
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk); #1;
      if (took) begin
        in_valid = 1'b0;
        sent++;
      end
    end
    check("rand_sent", sent, 1500);
    in_valid = 1'b0; out_ready = 1'b1;
    wait_idle();
    check("sb_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
